// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package serial_pkg;

   // Controller state encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/and_dly.sv
// Two-input AND gate primitive. DELAY describes the gate delay the
// surrounding clock must cover; the synthesizable form is zero-delay.
module and_dly #(
   parameter int DELAY = 1
) (
   input  logic a,
   input  logic b,
   output logic y
);

   if (DELAY < 0) begin : g_bad_delay
      $error("and_dly: DELAY must be non-negative");
   end

   assign y = a & b;

endmodule

// File: rtl/full_adder_dly.sv
// Gate-level full adder built from delayed gate primitives.
// Critical path is two gate delays: xor->xor for s, and->or3 for co.
module full_adder_dly #(
   parameter int DELAY = 1
) (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic xy_x;
   logic xy_a;
   logic xc_a;
   logic yc_a;

   xor_dly #(.DELAY(DELAY)) u_xor0 (.a(x),    .b(y),  .y(xy_x));
   xor_dly #(.DELAY(DELAY)) u_xor1 (.a(xy_x), .b(ci), .y(s));

   and_dly #(.DELAY(DELAY)) u_and0 (.a(x), .b(y),  .y(xy_a));
   and_dly #(.DELAY(DELAY)) u_and1 (.a(x), .b(ci), .y(xc_a));
   and_dly #(.DELAY(DELAY)) u_and2 (.a(y), .b(ci), .y(yc_a));

   or3_dly #(.DELAY(DELAY)) u_or (.a(xy_a), .b(xc_a), .c(yc_a), .y(co));

endmodule

// File: rtl/or3_dly.sv
// Three-input OR gate primitive. DELAY describes the gate delay the
// surrounding clock must cover; the synthesizable form is zero-delay.
module or3_dly #(
   parameter int DELAY = 1
) (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);

   if (DELAY < 0) begin : g_bad_delay
      $error("or3_dly: DELAY must be non-negative");
   end

   assign y = a | b | c;

endmodule

// File: rtl/xor_dly.sv
// Two-input XOR gate primitive. DELAY describes the gate delay the
// surrounding clock must cover; the synthesizable form is zero-delay.
module xor_dly #(
   parameter int DELAY = 1
) (
   input  logic a,
   input  logic b,
   output logic y
);

   if (DELAY < 0) begin : g_bad_delay
      $error("xor_dly: DELAY must be non-negative");
   end

   assign y = a ^ b;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one full adder stepped over WIDTH bits,
// LSB first, under an IDLE/RUN/DONE controller with start/done handshake.
module serial_add_seq
   import serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DELAY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_add_seq: WIDTH must be at least 2");
   end

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             c_q;
   logic             cout_q;
   logic             ovf_q;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   full_adder_dly #(.DELAY(DELAY)) u_fa (
      .x  (ra_q[0]),
      .y  (rb_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_bit = (cnt_q == CNT_LAST);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: accept in IDLE, step WIDTH bits, one DONE cycle.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE:               state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand load on accept, one full-adder step per RUN edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra_q   <= '0;
         rb_q   <= '0;
         sum_q  <= '0;
         cnt_q  <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         if (start) begin
            // Subtract as a + ~b + 1: the +1 enters as the initial carry.
            ra_q  <= a;
            rb_q  <= sub ? ~b : b;
            c_q   <= sub;
            cnt_q <= '0;
         end
      end else if (state_q == ST_RUN) begin
         ra_q  <= ra_q >> 1;
         rb_q  <= rb_q >> 1;
         sum_q <= {fa_s, sum_q[WIDTH-1:1]};
         c_q   <= fa_co;
         cnt_q <= cnt_q + 1'b1;
         if (last_bit) begin
            cout_q <= fa_co;
            // Carry into the MSB differs from carry out: signed overflow.
            ovf_q  <= c_q ^ fa_co;
         end
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
